// File: rtl/riscv_test_monitor_if.sv
// rtl/riscv_test_monitor_if.sv - writeback snoop and verdict bundle for riscv_test_monitor
//
// Purpose: groups the arm pulse, register-file writeback snoop and verdict
//          outputs of riscv_test_monitor into one bundle.
// Signals:
//   start         arm / re-arm pulse (driven by master)
//   wb_we/wb_rd/wb_data  register-file writeback snoop (driven by master)
//   busy          monitor is in RUN or DRAIN
//   done/pass/fail/timeout  verdict flags
//   fail_testnum  test number latched on a failing verdict
//   cycle_count   cycles spent in RUN plus DRAIN
// Modports: master = core/SoC side, slave = monitor.

interface riscv_test_monitor_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic            done;
    logic            pass;
    logic            fail;
    logic            timeout;
    logic [XLEN-1:0] fail_testnum;
    logic [31:0]     cycle_count;

    modport master (
        output start, wb_we, wb_rd, wb_data,
        input  busy, done, pass, fail, timeout, fail_testnum, cycle_count
    );

    modport slave (
        input  start, wb_we, wb_rd, wb_data,
        output busy, done, pass, fail, timeout, fail_testnum, cycle_count
    );
endinterface

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - riscv-tests completion monitor snooping register writeback
//
// Purpose: shadows the done/pass/test-number registers written by the core,
//          waits DRAIN_CYCLES after the done write, then latches a verdict.
// Ports:
//   clk  core clock
//   rst  synchronous active-high reset
//   bus  riscv_test_monitor_if.slave (start, writeback snoop, verdict outputs)
// Configuration: define TEST_MONITOR_TIMEOUT_EN to build the RUN-state
//   timeout counter; otherwise timeout is tied to 0.

module riscv_test_monitor #(
    parameter int XLEN           = 32,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int NUM_REG        = 3,
    parameter int DRAIN_CYCLES   = 5,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input logic                 clk,
    input logic                 rst,
    riscv_test_monitor_if.slave bus
);
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic            pass_sh_q, pass_sh_d;   // pass shadow reduced to "value == 1"
    logic [XLEN-1:0] num_sh_q, num_sh_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [31:0]     cc_q, cc_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic [XLEN-1:0] tnum_q, tnum_d;
`ifdef TEST_MONITOR_TIMEOUT_EN
    logic            tmo_q, tmo_d;
    logic [31:0]     run_q, run_d;
`endif

    logic            wr_any, wr_done, wr_pass, wr_num;
    logic            pass_eff;
    logic [XLEN-1:0] num_eff;

    // x0 is hardwired, so writes to it never reach a shadow even if an index parameter is 0.
    assign wr_any  = bus.wb_we && (bus.wb_rd != 5'd0);
    assign wr_done = wr_any && (bus.wb_rd == 5'(DONE_REG));
    assign wr_pass = wr_any && (bus.wb_rd == 5'(PASS_REG));
    assign wr_num  = wr_any && (bus.wb_rd == 5'(NUM_REG));

    // Verdict sees a write sampled on the same edge that enters DONE.
    assign pass_eff = wr_pass ? (bus.wb_data == XLEN'(1)) : pass_sh_q;
    assign num_eff  = wr_num  ? bus.wb_data : num_sh_q;

    always_comb begin
        state_d   = state_q;
        pass_sh_d = pass_sh_q;
        num_sh_d  = num_sh_q;
        drain_d   = drain_q;
        cc_d      = cc_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        tnum_d    = tnum_q;
`ifdef TEST_MONITOR_TIMEOUT_EN
        tmo_d     = tmo_q;
        run_d     = run_q;
`endif

        if (state_q != S_DONE) begin
            pass_sh_d = pass_eff;
            num_sh_d  = num_eff;
        end

        if ((state_q == S_RUN || state_q == S_DRAIN) && cc_q != 32'hFFFF_FFFF) begin
            cc_d = cc_q + 32'd1;
        end

        case (state_q)
            S_RUN: begin
                if (wr_done && bus.wb_data == XLEN'(1)) begin
                    state_d = S_DRAIN;
                    drain_d = DW'(DRAIN_CYCLES);
                end
`ifdef TEST_MONITOR_TIMEOUT_EN
                // Trip on the edge that completes TIMEOUT_CYCLES RUN edges.
                else if (({1'b0, run_q} + 33'd1) >= 33'(TIMEOUT_CYCLES)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = 1'b0;
                    fail_d  = 1'b1;
                    tmo_d   = 1'b1;
                    tnum_d  = num_eff;
                end else begin
                    run_d = run_q + 32'd1;
                end
`endif
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = pass_eff;
                    fail_d  = !pass_eff;
                    tnum_d  = pass_eff ? '0 : num_eff;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: ;
        endcase

        // start from any state (re)arms and discards any verdict in flight.
        if (bus.start) begin
            state_d   = S_RUN;
            pass_sh_d = 1'b0;
            num_sh_d  = '0;
            drain_d   = '0;
            cc_d      = '0;
            done_d    = 1'b0;
            pass_d    = 1'b0;
            fail_d    = 1'b0;
            tnum_d    = '0;
`ifdef TEST_MONITOR_TIMEOUT_EN
            tmo_d     = 1'b0;
            run_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pass_sh_q <= 1'b0;
            num_sh_q  <= '0;
            drain_q   <= '0;
            cc_q      <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            tnum_q    <= '0;
`ifdef TEST_MONITOR_TIMEOUT_EN
            tmo_q     <= 1'b0;
            run_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pass_sh_q <= pass_sh_d;
            num_sh_q  <= num_sh_d;
            drain_q   <= drain_d;
            cc_q      <= cc_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            tnum_q    <= tnum_d;
`ifdef TEST_MONITOR_TIMEOUT_EN
            tmo_q     <= tmo_d;
            run_q     <= run_d;
`endif
        end
    end

    assign bus.busy         = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.fail_testnum = tnum_q;
    assign bus.cycle_count  = cc_q;
`ifdef TEST_MONITOR_TIMEOUT_EN
    assign bus.timeout      = tmo_q;
`else
    assign bus.timeout      = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb/tb_riscv_test_monitor.sv - self-checking bench for riscv_test_monitor
module tb_riscv_test_monitor;
    localparam int XLEN = 32;
    localparam int D    = 5;
    localparam int TO   = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_test_monitor_if #(.XLEN(XLEN)) bus ();

    riscv_test_monitor #(
        .XLEN(XLEN), .DONE_REG(26), .PASS_REG(27), .NUM_REG(3),
        .DRAIN_CYCLES(D), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d);
        bus.wb_we = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
        step();
        bus.wb_we = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = '0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        idle(2);
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.fail_testnum, bus.cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b fail=%b tmo=%b tn=%0d cc=%0d want all 0",
                     bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.fail_testnum, bus.cycle_count);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_pass();
        pulse_start();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL pass_busy_rise got=%b want=1", bus.busy); end
        wr(5'd3, 32'd2);
        wr(5'd27, 32'd1);
        wr(5'd26, 32'd1);
        idle(5);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL pass_early got busy,done=%b want=10", {bus.busy, bus.done}); end
        step();
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b01100) begin
            errors++; $display("FAIL pass_flags got=%b want=01100", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout});
        end
        checks++;
        if (bus.fail_testnum !== 32'd0 || bus.cycle_count !== 32'd9) begin
            errors++; $display("FAIL pass_tn_cc got tn=%0d cc=%0d want tn=0 cc=9", bus.fail_testnum, bus.cycle_count);
        end
    endtask

    task automatic test_fail();
        pulse_start();
        wr(5'd3, 32'd5);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);
        idle(5);
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL fail_early got done=%b want=0", bus.done); end
        step();
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b01010) begin
            errors++; $display("FAIL fail_flags got=%b want=01010", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout});
        end
        checks++;
        if (bus.fail_testnum !== 32'd5 || bus.cycle_count !== 32'd9) begin
            errors++; $display("FAIL fail_tn_cc got tn=%0d cc=%0d want tn=5 cc=9", bus.fail_testnum, bus.cycle_count);
        end
    endtask

    task automatic test_late_pass();
        pulse_start();
        wr(5'd3, 32'd8);
        wr(5'd27, 32'd0);
        wr(5'd26, 32'd1);   // done write at edge 3
        idle(1);
        wr(5'd26, 32'd1);   // repeated done write must not restart the drain
        idle(3);
        wr(5'd27, 32'd1);   // edge 9: last drain cycle
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b01100) begin
            errors++; $display("FAIL late_pass_flags got=%b want=01100", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout});
        end
        checks++;
        if (bus.cycle_count !== 32'd9) begin errors++; $display("FAIL late_pass_cc got=%0d want=9", bus.cycle_count); end
        wr(5'd27, 32'd0);
        wr(5'd3, 32'd9);
        idle(3);
        checks++;
        if ({bus.done, bus.pass, bus.fail, bus.fail_testnum, bus.cycle_count} !== {3'b110, 32'd0, 32'd9}) begin
            errors++; $display("FAIL done_hold got done=%b pass=%b fail=%b tn=%0d cc=%0d want 1 1 0 0 9",
                               bus.done, bus.pass, bus.fail, bus.fail_testnum, bus.cycle_count);
        end
    endtask

    task automatic test_ignored_restart();
        pulse_start();
        checks++;
        if ({bus.done, bus.pass, bus.cycle_count} !== '0) begin
            errors++; $display("FAIL start_clears got done=%b pass=%b cc=%0d want 0", bus.done, bus.pass, bus.cycle_count);
        end
        wr(5'd0, 32'd1);
        wr(5'd26, 32'd2);
        idle(10);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL ignored_writes got busy,done=%b want=10", {bus.busy, bus.done}); end
        wr(5'd26, 32'd1);
        idle(2);
        pulse_start();
        checks++;
        if ({bus.busy, bus.done, bus.cycle_count} !== {2'b10, 32'd0}) begin
            errors++; $display("FAIL restart got busy=%b done=%b cc=%0d want 1 0 0", bus.busy, bus.done, bus.cycle_count);
        end
        idle(8);
        checks++;
        if ({bus.busy, bus.done, bus.cycle_count} !== {2'b10, 32'd8}) begin
            errors++; $display("FAIL restart_run got busy=%b done=%b cc=%0d want 1 0 8", bus.busy, bus.done, bus.cycle_count);
        end
    endtask

    task automatic test_reset_mid_drain();
        pulse_start();
        wr(5'd3, 32'd4);
        wr(5'd26, 32'd1);
        idle(2);
        rst = 1'b1;
        bus.start = 1'b1;
        wr(5'd26, 32'd1);
        rst = 1'b0;
        bus.start = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.fail_testnum, bus.cycle_count} !== '0) begin
            errors++; $display("FAIL rst_mid_drain got busy=%b done=%b cc=%0d want all 0", bus.busy, bus.done, bus.cycle_count);
        end
        wr(5'd26, 32'd1);
        idle(10);
        checks++;
        if ({bus.busy, bus.done, bus.fail, bus.cycle_count} !== '0) begin
            errors++; $display("FAIL idle_ignores_done got busy=%b done=%b cc=%0d want 0", bus.busy, bus.done, bus.cycle_count);
        end
    endtask

`ifdef TEST_MONITOR_TIMEOUT_EN
    task automatic test_timeout();
        pulse_start();
        wr(5'd3, 32'd7);
        idle(TO - 2);
        checks++;
        if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL timeout_early got busy,done=%b want=10", {bus.busy, bus.done}); end
        step();
        checks++;
        if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout} !== 5'b01011) begin
            errors++; $display("FAIL timeout_flags got=%b want=01011", {bus.busy, bus.done, bus.pass, bus.fail, bus.timeout});
        end
        checks++;
        if (bus.fail_testnum !== 32'd7 || bus.cycle_count !== 32'(TO)) begin
            errors++; $display("FAIL timeout_tn_cc got tn=%0d cc=%0d want tn=7 cc=%0d", bus.fail_testnum, bus.cycle_count, TO);
        end
    endtask
`endif

    // Random writeback traces; expected verdict comes from the last writes
    // to x27/x3 up to the judging edge, which sits D+1 edges after the done write.
    task automatic test_random();
        logic        we  [64];
        logic [4:0]  rd  [64];
        logic [31:0] dat [64];
        for (int it = 0; it < 10; it++) begin
            int p, l, judge;
            logic exp_pass;
            logic [31:0] exp_num, exp_tn;
            p = int'($urandom_range(1, 20));
            judge = p + D + 1;
            l = judge + 4;
            for (int j = 1; j <= l; j++) begin
                we[j] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 4))
                    0: rd[j] = 5'd0;
                    1: rd[j] = 5'd3;
                    2: rd[j] = 5'd26;
                    3: rd[j] = 5'd27;
                    default: rd[j] = 5'($urandom);
                endcase
                case ($urandom_range(0, 3))
                    0: dat[j] = 32'd0;
                    1: dat[j] = 32'd1;
                    2: dat[j] = 32'd2;
                    default: dat[j] = $urandom;
                endcase
                if (j < p && we[j] && rd[j] == 5'd26 && dat[j] == 32'd1) dat[j] = 32'd2;
                if (j == p) begin we[j] = 1'b1; rd[j] = 5'd26; dat[j] = 32'd1; end
            end
            exp_pass = 1'b0;
            exp_num  = '0;
            for (int j = 1; j <= judge; j++) begin
                if (we[j] && rd[j] == 5'd27) exp_pass = (dat[j] == 32'd1);
                if (we[j] && rd[j] == 5'd3)  exp_num  = dat[j];
            end
            exp_tn = exp_pass ? 32'd0 : exp_num;

            pulse_start();
            for (int j = 1; j <= l; j++) begin
                bus.wb_we = we[j]; bus.wb_rd = rd[j]; bus.wb_data = dat[j];
                step();
                if (j == judge - 1) begin
                    checks++;
                    if ({bus.busy, bus.done} !== 2'b10) begin
                        errors++; $display("FAIL rnd%0d_before got busy,done=%b want=10", it, {bus.busy, bus.done});
                    end
                end
                if (j == judge || j == l) begin
                    checks++;
                    if ({bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.fail_testnum, bus.cycle_count}
                        !== {2'b01, exp_pass, !exp_pass, 1'b0, exp_tn, 32'(judge)}) begin
                        errors++;
                        $display("FAIL rnd%0d_verdict@%0d got b=%b d=%b p=%b f=%b t=%b tn=%0h cc=%0d want b=0 d=1 p=%b f=%b t=0 tn=%0h cc=%0d",
                                 it, j, bus.busy, bus.done, bus.pass, bus.fail, bus.timeout, bus.fail_testnum,
                                 bus.cycle_count, exp_pass, !exp_pass, exp_tn, judge);
                    end
                end
            end
            bus.wb_we = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_late_pass();
        test_ignored_restart();
        test_reset_mid_drain();
`ifdef TEST_MONITOR_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
